// File: rtl/if_id_queue_if.sv
// Fetch/ID-side bundle for the instruction fetch queue: fetch write slot,
// ID flush/stall controls, occupancy status and the head-of-queue view.
interface if_id_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic                       flush_i;
    logic [5:0]                 stall_i;
    logic                       wr_valid_i;
    logic [ADDR_W-1:0]          pc_i;
    logic [INST_W-1:0]          inst_i;
    logic                       prediction_i;
    logic [ADDR_W-1:0]          prediction_pc_i;
    logic                       full_o;
    logic [$clog2(DEPTH):0]     count_o;
    logic                       drop_o;
    logic                       id_valid_o;
    logic [ADDR_W-1:0]          id_pc_o;
    logic [INST_W-1:0]          id_inst_o;
    logic                       id_prediction_o;
    logic [ADDR_W-1:0]          id_prediction_pc_o;

    // Fetch / control side drives the queue inputs.
    modport master (
        output flush_i, stall_i, wr_valid_i, pc_i, inst_i, prediction_i, prediction_pc_i,
        input  full_o, count_o, drop_o, id_valid_o, id_pc_o, id_inst_o,
               id_prediction_o, id_prediction_pc_o
    );

    modport slave (
        input  flush_i, stall_i, wr_valid_i, pc_i, inst_i, prediction_i, prediction_pc_i,
        output full_o, count_o, drop_o, id_valid_o, id_pc_o, id_inst_o,
               id_prediction_o, id_prediction_pc_o
    );
endinterface

// File: rtl/if_id_queue.sv
// Instruction fetch queue between IF and ID: circular buffer of fetched
// instructions with their prediction tags, single-cycle flush on mispredict.
module if_id_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    if_id_queue_if.slave q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [INST_W-1:0] NOP = INST_W'(32'h0000_0013);

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic              pred_mem [DEPTH];
    logic [ADDR_W-1:0] ppc_mem  [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             drop_q;
    logic             not_empty;
    logic             deq;
    logic             enq;
    logic             unused_stall;

    // Only the ID hold bit matters here; the other stall bits belong to other stages.
    assign unused_stall = ^{q.stall_i[5:2], q.stall_i[0]};

    assign not_empty = (cnt != '0);
    assign deq       = not_empty & ~q.stall_i[1] & ~q.flush_i;
    // A full queue still accepts a write when the head leaves in the same cycle.
    assign enq       = q.wr_valid_i & ~q.flush_i & ((cnt < CNT_W'(DEPTH)) | deq);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            drop_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
                pred_mem[i] <= 1'b0;
                ppc_mem[i]  <= '0;
            end
        end else begin
            drop_q <= q.wr_valid_i & ~q.flush_i & ~enq;
            if (q.flush_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (enq) begin
                    pc_mem[wr_ptr]   <= q.pc_i;
                    inst_mem[wr_ptr] <= q.inst_i;
                    pred_mem[wr_ptr] <= q.prediction_i;
                    ppc_mem[wr_ptr]  <= q.prediction_pc_i;
                    wr_ptr           <= wr_ptr + PTR_W'(1);
                end
                if (deq) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({enq, deq})
                    2'b10:   cnt <= cnt + CNT_W'(1);
                    2'b01:   cnt <= cnt - CNT_W'(1);
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    assign q.full_o     = (cnt == CNT_W'(DEPTH));
    assign q.count_o    = cnt;
    assign q.drop_o     = drop_q;
    assign q.id_valid_o = not_empty;

    // Head view falls back to a NOP bubble whenever the queue is empty.
    always_comb begin
        q.id_pc_o            = '0;
        q.id_inst_o          = NOP;
        q.id_prediction_o    = 1'b0;
        q.id_prediction_pc_o = '0;
        if (not_empty) begin
            q.id_pc_o            = pc_mem[rd_ptr];
            q.id_inst_o          = inst_mem[rd_ptr];
            q.id_prediction_o    = pred_mem[rd_ptr];
            q.id_prediction_pc_o = ppc_mem[rd_ptr];
        end
    end
endmodule
